cmd_bus_arbiter: RTL and testbench
==================================

// Module: cmd_bus_arbiter
// PURPOSE
//  Shares the single radio command bus (cmd_addr/cmd_data/cmd_rqst) between two
//  requesters: the host SPI command path and the local command sequencer
//  (power-up init, ATU/PA housekeeping). Grants round-robin and issues one
//  command at a time. Waits for the slave ack or an ack timeout, then enforces
//  an idle gap. Runs in the clk_internal domain and feeds ad9866ctrl/control.
// PARAMETERS
//  ACK_TIMEOUT  1024  cycles spent in WAIT_ACK before a command is abandoned (>=2)
//  GAP_CYCLES   2     idle cycles inserted after each command (0 = no gap)
// PORTS
//  clk           in   1   clk_internal
//  rst           in   1   synchronous, active-high reset
//  host_valid    in   1   host command pending
//  host_ready    out  1   host command accepted this cycle (valid&ready)
//  host_addr     in   6   host command address
//  host_data     in   32  host command payload
//  loc_valid     in   1   local sequencer command pending
//  loc_ready     out  1   local command accepted this cycle
//  loc_addr      in   6   local command address
//  loc_data      in   32  local command payload
//  cmd_addr      out  6   registered command address to slaves
//  cmd_data      out  32  registered command payload to slaves
//  cmd_rqst      out  1   one-cycle strobe: command valid on cmd_addr/cmd_data
//  cmd_ack       in   1   slave completion strobe
//  busy          out  1   high in any state other than IDLE
//  grant_loc     out  1   source of current/last command (1=local, 0=host)
//  to_pulse      out  1   one-cycle strobe on ack timeout
//  to_count      out  8   saturating ack-timeout counter
// BEHAVIOUR
//  Reset: all outputs 0; grant_loc=1, so the host wins the first tie; state=IDLE.
//  States: IDLE -> ISSUE -> WAIT_ACK -> GAP -> IDLE.
//   IDLE: ready is combinational and only asserted here. If only one valid is
//    high, grant that source. If both are high, grant the source that was not
//    granted last (opposite of grant_loc). On accept, register addr/data into
//    cmd_addr/cmd_data, update grant_loc, and go to ISSUE. At most one ready per
//    cycle.
//   ISSUE: cmd_rqst=1 for exactly this cycle. If cmd_ack=1 in this same cycle,
//    go to GAP. Otherwise go to WAIT_ACK and clear the timeout counter.
//   WAIT_ACK: when cmd_ack=1, go to GAP. If the counter reaches ACK_TIMEOUT-1
//    without an ack: to_pulse=1, to_count+=1 (saturates at 255), go to GAP.
//    If ack and the terminal count coincide, the ack wins and there is no timeout.
//   GAP: hold for GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, go from
//    ISSUE/WAIT_ACK straight to IDLE.
//  cmd_ack in IDLE or GAP is ignored (stale acks are dropped).
//  cmd_addr/cmd_data hold their value from accept until the next accept.
//  Latency: accept at cycle N gives cmd_rqst at N+1. The minimum accept-to-accept
//   period is 2+GAP_CYCLES cycles (ack in ISSUE).
//  A requester may drop valid before ready; no command is issued in that case.
//  Payloads are latched only on accept; input changes afterwards have no effect.
//  rst mid-operation: return to IDLE next cycle. No cmd_rqst and no to_pulse are
//   generated; to_count clears; any in-flight command is abandoned.
//  ACK_TIMEOUT counter width is $clog2(ACK_TIMEOUT).
// TESTING
//  1. host_valid only, addr=6'h09 data=32'h1234_5678, ack 3 cycles after rqst:
//     host_ready at N, cmd_rqst at N+1 with those values, busy low after the gap.
//  2. Both valid, held continuously, instant acks, GAP_CYCLES=2: grants go
//     host, loc, host, loc...; accepts are 4 cycles apart.
//  3. No ack, ACK_TIMEOUT=16: to_pulse 16 cycles after entering WAIT_ACK and
//     to_count=1; after 300 such commands, to_count=255.
//  4. cmd_ack in the same cycle as the terminal count: no to_pulse, to_count
//     unchanged.
//  5. rst asserted in WAIT_ACK: IDLE next cycle, all outputs 0, grant_loc=1.
//     A following tie is granted to the host.
//  6. Stale cmd_ack pulses in IDLE and GAP, with no valids: no state change,
//     no cmd_rqst.

Source files
------------

// File: rtl/cmd_bus_arbiter.sv
// Two-source round-robin arbiter for the radio command bus.
// Issues one command at a time, waits for the slave ack or a timeout,
// then holds an idle gap before the next grant.
module cmd_bus_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_data,
    input  logic        loc_valid,
    output logic        loc_ready,
    input  logic [5:0]  loc_addr,
    input  logic [31:0] loc_data,
    output logic [5:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_rqst,
    input  logic        cmd_ack,
    output logic        busy,
    output logic        grant_loc,
    output logic        to_pulse,
    output logic [7:0]  to_count
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        GAP
    } state_t;

    // With no gap configured the command phase returns straight to IDLE.
    localparam state_t AFTER_CMD = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t        state, state_nx;
    logic [TW-1:0] to_cnt, to_cnt_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic          grant_loc_nx;
    logic [5:0]    cmd_addr_nx;
    logic [31:0]   cmd_data_nx;
    logic          to_pulse_nx;
    logic [7:0]    to_count_nx;
    logic          pick_host;
    logic          pick_loc;

    assign busy = (state != IDLE);

    // Next-state, handshake and strobe generation
    always_comb begin
        state_nx     = state;
        to_cnt_nx    = to_cnt;
        gap_cnt_nx   = gap_cnt;
        grant_loc_nx = grant_loc;
        cmd_addr_nx  = cmd_addr;
        cmd_data_nx  = cmd_data;
        to_pulse_nx  = 1'b0;
        to_count_nx  = to_count;
        host_ready   = 1'b0;
        loc_ready    = 1'b0;
        cmd_rqst     = 1'b0;
        // On a tie the source not granted last wins.
        pick_host    = host_valid && (!loc_valid || grant_loc);
        pick_loc     = loc_valid && (!host_valid || !grant_loc);

        case (state)
            IDLE: begin
                host_ready = pick_host && !rst;
                loc_ready  = pick_loc && !rst;
                if (pick_host) begin
                    cmd_addr_nx  = host_addr;
                    cmd_data_nx  = host_data;
                    grant_loc_nx = 1'b0;
                    state_nx     = ISSUE;
                end else if (pick_loc) begin
                    cmd_addr_nx  = loc_addr;
                    cmd_data_nx  = loc_data;
                    grant_loc_nx = 1'b1;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                cmd_rqst   = !rst;
                to_cnt_nx  = '0;
                gap_cnt_nx = '0;
                state_nx   = cmd_ack ? AFTER_CMD : WAIT_ACK;
            end
            WAIT_ACK: begin
                gap_cnt_nx = '0;
                // An ack on the terminal count takes priority over the timeout.
                if (cmd_ack) begin
                    state_nx = AFTER_CMD;
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    to_pulse_nx = 1'b1;
                    to_count_nx = (to_count == 8'hFF) ? to_count : to_count + 8'd1;
                    state_nx    = AFTER_CMD;
                end else begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            grant_loc <= 1'b1;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            to_pulse  <= 1'b0;
            to_count  <= '0;
        end else begin
            state     <= state_nx;
            to_cnt    <= to_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            grant_loc <= grant_loc_nx;
            cmd_addr  <= cmd_addr_nx;
            cmd_data  <= cmd_data_nx;
            to_pulse  <= to_pulse_nx;
            to_count  <= to_count_nx;
        end
    end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Randomized bench for cmd_bus_arbiter against a cycle-timeline reference model.
module tb_cmd_bus_arbiter;

    localparam int ACK_TO = 16;
    localparam int GAP    = 2;
    localparam int NEVER  = 32'h7fff_ffff;

    logic        clk;
    logic        rst;
    logic        host_valid, host_ready;
    logic [5:0]  host_addr;
    logic [31:0] host_data;
    logic        loc_valid, loc_ready;
    logic [5:0]  loc_addr;
    logic [31:0] loc_data;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst, cmd_ack, busy, grant_loc, to_pulse;
    logic [7:0]  to_count;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_bus_arbiter #(
        .ACK_TIMEOUT(ACK_TO),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_addr (host_addr),
        .host_data (host_data),
        .loc_valid (loc_valid),
        .loc_ready (loc_ready),
        .loc_addr  (loc_addr),
        .loc_data  (loc_data),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_rqst  (cmd_rqst),
        .cmd_ack   (cmd_ack),
        .busy      (busy),
        .grant_loc (grant_loc),
        .to_pulse  (to_pulse),
        .to_count  (to_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks when the bus is free again, the cycle of the
    // request strobe and the window in which an ack is honoured.
    int          cyc         = 0;
    bit          m_valid     = 0;
    bit          m_wait      = 0;
    int          m_idle_at   = 0;
    int          m_rqst_cyc  = -1;
    int          m_pulse_cyc = -1;
    bit          m_grant_loc = 1;
    logic [7:0]  m_to_count  = '0;
    logic [5:0]  m_addr      = '0;
    logic [31:0] m_data      = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycles(input int n, input int mode);
        bit m_idle, exp_hr, exp_lr, exp_rq;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            host_addr = 6'($urandom);
            host_data = $urandom;
            loc_addr  = 6'($urandom);
            loc_data  = $urandom;
            case (mode)
                0: begin
                    host_valid = 1'($urandom_range(0, 1));
                    loc_valid  = 1'($urandom_range(0, 1));
                    cmd_ack    = ($urandom_range(0, 9) < 3);
                    rst        = ($urandom_range(0, 199) == 0);
                end
                1: begin host_valid = 1; loc_valid = 1; cmd_ack = 1; end
                2: begin host_valid = 1; loc_valid = 0; cmd_ack = 0; end
                3: begin
                    host_valid = 1'($urandom_range(0, 1));
                    loc_valid  = 1;
                    cmd_ack    = m_wait && (cyc == m_rqst_cyc + ACK_TO);
                end
                4: begin
                    host_valid = 0; loc_valid = 0;
                    cmd_ack    = 1'($urandom_range(0, 1));
                end
                5: begin
                    host_valid = 1; loc_valid = 1; cmd_ack = 0;
                    rst        = m_wait && (cyc == m_rqst_cyc + 5);
                end
                6: begin
                    host_valid = 1; loc_valid = 0;
                    host_addr  = 6'h09;
                    host_data  = 32'h1234_5678;
                    cmd_ack    = m_wait && (cyc == m_rqst_cyc + 3);
                end
                default: begin host_valid = 0; loc_valid = 0; cmd_ack = 0; rst = 1; end
            endcase
            #1;
            m_idle = (cyc >= m_idle_at);
            exp_hr = !rst && m_idle && host_valid && (!loc_valid || m_grant_loc);
            exp_lr = !rst && m_idle && loc_valid && (!host_valid || !m_grant_loc);
            exp_rq = !rst && m_wait && (cyc == m_rqst_cyc);
            if (m_valid) begin
                check_eq("host_ready", host_ready, exp_hr);
                check_eq("loc_ready", loc_ready, exp_lr);
                check_eq("cmd_rqst", cmd_rqst, exp_rq);
                if (!rst) check_eq("busy", busy, !m_idle);
                check_eq("grant_loc", grant_loc, m_grant_loc);
                check_eq("cmd_addr", cmd_addr, m_addr);
                check_eq("cmd_data", cmd_data, m_data);
                check_eq("to_pulse", to_pulse, (cyc == m_pulse_cyc));
                check_eq("to_count", to_count, m_to_count);
            end
            if (rst) begin
                m_valid     = 1;
                m_wait      = 0;
                m_idle_at   = cyc + 1;
                m_pulse_cyc = -1;
                m_grant_loc = 1;
                m_to_count  = '0;
                m_addr      = '0;
                m_data      = '0;
            end else if (m_valid) begin
                if (exp_hr || exp_lr) begin
                    m_addr      = exp_hr ? host_addr : loc_addr;
                    m_data      = exp_hr ? host_data : loc_data;
                    m_grant_loc = exp_lr;
                    m_rqst_cyc  = cyc + 1;
                    m_wait      = 1;
                    m_idle_at   = NEVER;
                end else if (m_wait && cyc >= m_rqst_cyc) begin
                    if (cmd_ack) begin
                        m_wait    = 0;
                        m_idle_at = cyc + 1 + GAP;
                    end else if (cyc == m_rqst_cyc + ACK_TO) begin
                        m_wait      = 0;
                        m_idle_at   = cyc + 1 + GAP;
                        m_pulse_cyc = cyc + 1;
                        if (m_to_count != 8'hFF) m_to_count = m_to_count + 8'd1;
                    end
                end
            end
            cyc++;
        end
    endtask

    initial begin
        rst = 1; host_valid = 0; loc_valid = 0; cmd_ack = 0;
        host_addr = '0; host_data = '0; loc_addr = '0; loc_data = '0;
        run_cycles(3, 7);
        run_cycles(40, 6);
        run_cycles(40, 1);
        run_cycles(200, 3);
        run_cycles(60, 4);
        run_cycles(120, 5);
        run_cycles(6100, 2);
        check_eq("to_count_sat", to_count, 8'd255);
        run_cycles(3000, 0);
        run_cycles(30, 4);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
